// File: rtl/nn_cell_binarizer.sv
// Sudoku cell binarizer: thresholds a raster pixel stream into a 784-bit vector and launches the
// digit network, or reports a near-blank cell. Define NN_BIN_INVERT_EN for dark-ink-on-light capture.
`timescale 1ns/1ps

module nn_cell_binarizer #(
    parameter int         IMG_W   = 28,
    parameter int         IMG_H   = 28,
    parameter logic [9:0] MIN_INK = 10'd12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic                   pix_sof,
    input  logic [7:0]             pix_data,
    input  logic [7:0]             thresh,
    output logic [IMG_W*IMG_H-1:0] layer_0,
    output logic                   nn_start,
    input  logic                   nn_finish,
    output logic [9:0]             ink_count,
    output logic                   blank_cell,
    output logic                   frame_err,
    output logic                   busy
);
    localparam int NPIX = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LAUNCH  = 2'd2,
        WAIT_NN = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [9:0]        count_reg;
    logic [9:0]        ink_run_reg;
    logic [7:0]        thresh_reg;
    logic [NPIX-1:0]   shadow_reg;
    logic [NPIX-1:0]   shadow_next;
    logic [NPIX-1:0]   layer_reg;
    logic [9:0]        ink_count_reg;
    logic              frame_err_reg;

    logic              accept;
    logic              restart;
    logic              step;
    logic              last_pix;
    logic [7:0]        thr_eff;
    logic              pix_bit;
    logic [9:0]        wr_idx;
    logic              enough_ink;

    assign accept   = pix_valid && pix_ready;
    // An SOF beat always begins a fresh frame, whether we were idle or mid-frame.
    assign restart  = accept && pix_sof;
    assign step     = accept && !pix_sof && (state_reg == COLLECT);
    assign last_pix = step && (count_reg == 10'(NPIX - 1));
    assign wr_idx   = 10'(NPIX - 1) - count_reg;

    // The SOF beat itself must be judged against the threshold that arrives with it.
    assign thr_eff  = pix_sof ? thresh : thresh_reg;

`ifdef NN_BIN_INVERT_EN
    assign pix_bit = (pix_data < thr_eff);
`else
    assign pix_bit = (pix_data >= thr_eff);
`endif

    assign enough_ink = (ink_count_reg >= MIN_INK);

    // Per-bit shadow update: restart clears everything but pixel 0, a normal beat writes one bit.
    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_shadow
            if (gi == NPIX - 1) begin : g_first
                assign shadow_next[gi] = restart ? pix_bit :
                                         (step && wr_idx == 10'(gi)) ? pix_bit : shadow_reg[gi];
            end else begin : g_rest
                assign shadow_next[gi] = restart ? 1'b0 :
                                         (step && wr_idx == 10'(gi)) ? pix_bit : shadow_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            ink_run_reg   <= '0;
            thresh_reg    <= '0;
            shadow_reg    <= '0;
            layer_reg     <= '0;
            ink_count_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shadow_reg    <= shadow_next;
            frame_err_reg <= restart && (state_reg == COLLECT);
            if (restart) begin
                thresh_reg  <= thresh;
                count_reg   <= 10'd1;
                ink_run_reg <= {9'd0, pix_bit};
            end else if (step) begin
                count_reg   <= count_reg + 10'd1;
                ink_run_reg <= ink_run_reg + {9'd0, pix_bit};
            end
            // The output vector only moves here, so it is frozen for the whole inference.
            if (last_pix) begin
                layer_reg     <= {shadow_reg[NPIX-1:1], pix_bit};
                ink_count_reg <= ink_run_reg + {9'd0, pix_bit};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pix_ready  = 1'b0;
        nn_start   = 1'b0;
        blank_cell = 1'b0;
        unique case (state_reg)
            IDLE: begin
                pix_ready = 1'b1;
                if (restart) state_next = COLLECT;
            end
            COLLECT: begin
                pix_ready = 1'b1;
                if (last_pix) state_next = LAUNCH;
            end
            LAUNCH: begin
                if (enough_ink) begin
                    nn_start   = 1'b1;
                    state_next = WAIT_NN;
                end else begin
                    blank_cell = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_NN: begin
                if (nn_finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign layer_0   = layer_reg;
    assign ink_count = ink_count_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_nn_cell_binarizer.sv
// Directed bench for nn_cell_binarizer: per-frame expectations are queued when a frame is
// driven and popped when the DUT launches or reports a blank cell.
`timescale 1ns/1ps

module tb_nn_cell_binarizer;
    localparam int NPIX = 784;

`ifdef NN_BIN_INVERT_EN
    localparam logic [9:0] EXP1_INK = 10'd560;
    localparam logic       EXP1_B10 = 1'b0;
    localparam logic       EXP1_B0  = 1'b1;
    localparam logic [9:0] EXP5_INK = 10'd0;
`else
    localparam logic [9:0] EXP1_INK = 10'd224;
    localparam logic       EXP1_B10 = 1'b1;
    localparam logic       EXP1_B0  = 1'b0;
    localparam logic [9:0] EXP5_INK = 10'd784;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pix_valid = 1'b0;
    logic            pix_ready;
    logic            pix_sof = 1'b0;
    logic [7:0]      pix_data = 8'd0;
    logic [7:0]      thresh = 8'd0;
    logic [NPIX-1:0] layer_0;
    logic            nn_start;
    logic            nn_finish = 1'b0;
    logic [9:0]      ink_count;
    logic            blank_cell;
    logic            frame_err;
    logic            busy;

    typedef struct {
        logic            launch;
        logic [9:0]      ink;
        logic [NPIX-1:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pix [NPIX];
    int checks = 0;
    int errors = 0;
    int launches = 0;
    int blanks = 0;
    int ferrs = 0;
    int exp_launches = 0;
    int exp_blanks = 0;

    nn_cell_binarizer dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .thresh     (thresh),
        .layer_0    (layer_0),
        .nn_start   (nn_start),
        .nn_finish  (nn_finish),
        .ink_count  (ink_count),
        .blank_cell (blank_cell),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [NPIX-1:0] obs, input logic [NPIX-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic model_bit(input logic [7:0] d, input logic [7:0] t);
`ifdef NN_BIN_INVERT_EN
        return d < t;
`else
        return d >= t;
`endif
    endfunction

    function automatic exp_t model_frame(input logic [7:0] t);
        exp_t e;
        logic b;
        e.ink = '0;
        e.vec = '0;
        for (int p = 0; p < NPIX; p++) begin
            b = model_bit(pix[p], t);
            e.vec[NPIX-1-p] = b;
            e.ink += {9'd0, b};
        end
        e.launch = (e.ink >= 10'd12);
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        exp_q.push_back(e);
        if (e.launch) exp_launches++;
        else exp_blanks++;
    endtask

    // Scoreboard side: every launch or blank report consumes one queued frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferrs++;
            if (nn_start) launches++;
            if (blank_cell) blanks++;
            if (nn_start || blank_cell) begin
                exp_t e;
                chk("start_blank_exclusive", {783'd0, nn_start & blank_cell}, '0);
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected: observed result with empty queue, required none");
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_kind", {783'd0, nn_start}, {783'd0, e.launch});
                    chk("sb_ink", {774'd0, ink_count}, {774'd0, e.ink});
                    chk("sb_layer", layer_0, e.vec);
                end
            end
        end
    end

    // Drives beats first..first+n-1 of pix[]; SOF on index 0; thresh only meaningful on SOF.
    task automatic send_beats(input int first, input int n, input logic [7:0] th, input bit rnd);
        int idx = first;
        int guard = 0;
        while (idx < first + n) begin
            @(negedge clk);
            if (rnd && $urandom_range(0, 1) == 0) begin
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = pix[idx];
                pix_sof   = (idx == 0);
                thresh    = (idx == 0) ? th : ~th;
                if (pix_ready) idx++;
            end
            guard++;
            if (guard > 20000) begin
                chk("send_timeout", 784'(idx), 784'(first + n));
                break;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Called at the negedge right after the last beat: the DUT must be in LAUNCH now.
    task automatic end_frame(input exp_t e, input int hold);
        bit seen_ready;
        chk("nn_start_latency", {783'd0, nn_start}, {783'd0, e.launch});
        chk("blank_cell", {783'd0, blank_cell}, {783'd0, !e.launch});
        chk("ink_count", {774'd0, ink_count}, {774'd0, e.ink});
        chk("layer_launch", layer_0, e.vec);
        chk("ready_launch", {783'd0, pix_ready}, '0);
        chk("busy_launch", {783'd0, busy}, {783'd0, 1'b1});
        if (e.launch) begin
            seen_ready = 1'b0;
            pix_valid  = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                pix_data = 8'($urandom);
                pix_sof  = 1'($urandom_range(0, 1));
                if (pix_ready) seen_ready = 1'b1;
            end
            chk("ready_wait", {783'd0, seen_ready}, '0);
            chk("busy_wait", {783'd0, busy}, {783'd0, 1'b1});
            chk("layer_hold", layer_0, e.vec);
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            nn_finish = 1'b1;
            @(negedge clk);
            nn_finish = 1'b0;
            chk("busy_done", {783'd0, busy}, '0);
            chk("ready_done", {783'd0, pix_ready}, {783'd0, 1'b1});
        end else begin
            @(negedge clk);
            chk("busy_idle", {783'd0, busy}, '0);
        end
    endtask

    initial begin
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_layer", layer_0, '0);
        chk("rst_ink", {774'd0, ink_count}, '0);
        chk("rst_start", {783'd0, nn_start}, '0);
        chk("rst_blank", {783'd0, blank_cell}, '0);
        chk("rst_ferr", {783'd0, frame_err}, '0);
        chk("rst_busy", {783'd0, busy}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {783'd0, pix_ready}, {783'd0, 1'b1});

        // Stray nn_finish while idle changes nothing
        nn_finish = 1'b1;
        @(negedge clk);
        nn_finish = 1'b0;
        @(negedge clk);
        chk("finish_ignored", {783'd0, busy}, '0);

        // 1: vertical stroke in columns 10..17
        for (int p = 0; p < NPIX; p++) pix[p] = (p % 28 >= 10 && p % 28 < 18) ? 8'd200 : 8'd20;
        e = model_frame(8'd128);
        push_exp(e);
        send_beats(0, NPIX, 8'd128, 1'b0);
        end_frame(e, 5);
        chk("s1_ink", {774'd0, ink_count}, {774'd0, EXP1_INK});
        chk("s1_bit10", {783'd0, layer_0[NPIX-1-10]}, {783'd0, EXP1_B10});
        chk("s1_bit0", {783'd0, layer_0[NPIX-1]}, {783'd0, EXP1_B0});

        // 2: near-blank cell, five saturated pixels
        for (int p = 0; p < NPIX; p++) pix[p] = 8'd0;
        pix[3] = 8'd255; pix[100] = 8'd255; pix[400] = 8'd255; pix[650] = 8'd255; pix[783] = 8'd255;
        e = model_frame(8'd128);
        push_exp(e);
        send_beats(0, NPIX, 8'd128, 1'b0);
        end_frame(e, 5);

        // 3: frame restarted by SOF at beat 300
        for (int p = 0; p < NPIX; p++) pix[p] = 8'd255;
        send_beats(0, 300, 8'd128, 1'b0);
        for (int p = 0; p < NPIX; p++) pix[p] = ((p / 28 + p) % 3 == 0) ? 8'd180 : 8'd60;
        e = model_frame(8'd100);
        push_exp(e);
        send_beats(0, NPIX, 8'd100, 1'b0);
        end_frame(e, 5);
        chk("s3_frame_err_count", 784'(ferrs), 784'(1));

        // 4: bursty valid, long inference
        for (int p = 0; p < NPIX; p++) pix[p] = 8'((p * 37) % 256);
        e = model_frame(8'd100);
        push_exp(e);
        send_beats(0, NPIX, 8'd100, 1'b1);
        end_frame(e, 1000);

        // 5: reset mid-frame, then a clean saturated frame
        for (int p = 0; p < NPIX; p++) pix[p] = 8'd255;
        send_beats(0, 400, 8'd128, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("s5_rst_layer", layer_0, '0);
        chk("s5_rst_ink", {774'd0, ink_count}, '0);
        chk("s5_rst_busy", {783'd0, busy}, '0);
        e = model_frame(8'd128);
        push_exp(e);
        send_beats(0, NPIX, 8'd128, 1'b0);
        end_frame(e, 5);
        chk("s5_ink", {774'd0, ink_count}, {774'd0, EXP5_INK});

        repeat (3) @(negedge clk);
        chk("queue_empty", 784'(exp_q.size()), '0);
        chk("launch_count", 784'(launches), 784'(exp_launches));
        chk("blank_count", 784'(blanks), 784'(exp_blanks));
        chk("frame_err_total", 784'(ferrs), 784'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
